// File: rtl/mux_n_reg_arb.sv
// N:1 multiplexer with a registered output stage, direct-select or round-robin
// arbitration, selector range checking and valid/ready back-pressure.
module mux_n_reg_arb #(
    parameter int NBits     = 32,
    parameter int NChannels = 4,
    parameter int SelBits   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_Mode,
    input  logic [SelBits-1:0]         in_Sel,
    input  logic [NChannels*NBits-1:0] in_Data,
    input  logic [NChannels-1:0]       in_Valid,
    output logic [NChannels-1:0]       out_Grant,
    output logic [NBits-1:0]           out_Data,
    output logic                       out_Valid,
    output logic [SelBits-1:0]         out_Sel,
    input  logic                       in_Ready,
    output logic                       out_SelError
);

    // Handshake: a producer's word is taken when its out_Grant bit is high in
    // the same cycle; the held word is consumed at a clock edge where
    // out_Valid && in_Ready, and stays frozen while out_Valid && !in_Ready.

    localparam int SelSpan = 2 ** SelBits;

    logic [NBits-1:0]   r_data;
    logic               r_valid;
    logic [SelBits-1:0] r_sel;
    logic               r_sel_err;
    logic [SelBits-1:0] r_rr_ptr;

    logic [SelSpan-1:0] w_valid_ext;
    logic               w_can_load;
    logic               w_sel_in_range;
    logic               w_direct_found;
    logic               w_rr_found;
    logic [SelBits-1:0] w_rr_idx;
    logic               w_win_found;
    logic [SelBits-1:0] w_win_idx;
    logic               w_capture;
    logic [NBits-1:0]   w_mux_data;
    logic [NChannels-1:0] w_grant;
    int                 w_dist;
    int                 w_best;

    // Padding to the full selector span lets in_Sel index safely even when it
    // points past the last real channel.
    assign w_valid_ext    = SelSpan'(in_Valid);
    assign w_can_load     = !r_valid || in_Ready;
    assign w_sel_in_range = ({1'b0, in_Sel} < (SelBits + 1)'(NChannels));
    assign w_direct_found = w_sel_in_range && w_valid_ext[in_Sel];

    // Round-robin: the winner is the valid channel closest after r_rr_ptr.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_best     = NChannels;
        w_dist     = 0;
        for (int c = 0; c < NChannels; c++) begin
            w_dist = c - int'(r_rr_ptr) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NChannels;
            end
            if (in_Valid[c] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_rr_found = 1'b1;
                w_rr_idx   = SelBits'(c);
            end
        end
    end

    assign w_win_found = in_Mode ? w_rr_found : w_direct_found;
    assign w_win_idx   = in_Mode ? w_rr_idx   : in_Sel;
    assign w_capture   = !reset && w_can_load && w_win_found;

    always_comb begin
        w_grant = '0;
        for (int c = 0; c < NChannels; c++) begin
            if (w_capture && (w_win_idx == SelBits'(c))) begin
                w_grant[c] = 1'b1;
            end
        end
    end

    // Data is only muxed from real channels, so no undefined word can latch.
    always_comb begin
        w_mux_data = '0;
        for (int c = 0; c < NChannels; c++) begin
            if (w_win_idx == SelBits'(c)) begin
                w_mux_data = in_Data[c*NBits +: NBits];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_sel     <= '0;
            r_sel_err <= 1'b0;
            r_rr_ptr  <= SelBits'(NChannels - 1);
        end else begin
            if (w_capture) begin
                r_data  <= w_mux_data;
                r_sel   <= w_win_idx;
                r_valid <= 1'b1;
                if (in_Mode) begin
                    r_rr_ptr <= w_win_idx;
                end
            end else if (in_Ready) begin
                r_valid <= 1'b0;
            end
            r_sel_err <= !in_Mode && !w_sel_in_range && w_can_load;
        end
    end

    assign out_Grant    = w_grant;
    assign out_Data     = r_data;
    assign out_Valid    = r_valid;
    assign out_Sel      = r_sel;
    assign out_SelError = r_sel_err;

endmodule

// File: tb/tb_mux_n_reg_arb.sv
// Scoreboarded bench for mux_n_reg_arb: a driver predicts grants and captured
// words from a queue-based model; a negedge monitor checks the held word stream.
module tb_mux_n_reg_arb;
  localparam int NB = 8;
  localparam int NC = 3;
  localparam int SB = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_Mode;
  logic [SB-1:0]      in_Sel;
  logic [NC*NB-1:0]   in_Data;
  logic [NC-1:0]      in_Valid;
  logic [NC-1:0]      out_Grant;
  logic [NB-1:0]      out_Data;
  logic               out_Valid;
  logic [SB-1:0]      out_Sel;
  logic               in_Ready;
  logic               out_SelError;

  mux_n_reg_arb #(.NBits(NB), .NChannels(NC), .SelBits(SB)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_Mode      (in_Mode),
    .in_Sel       (in_Sel),
    .in_Data      (in_Data),
    .in_Valid     (in_Valid),
    .out_Grant    (out_Grant),
    .out_Data     (out_Data),
    .out_Valid    (out_Valid),
    .out_Sel      (out_Sel),
    .in_Ready     (in_Ready),
    .out_SelError (out_SelError)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard state: the held word is tracked as {sel, data}
  logic [SB+NB-1:0] exp_q[$];
  bit m_valid = 1'b0;
  bit m_err   = 1'b0;
  int m_last  = NC - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // driver: called at posedge+1, applies one cycle of stimulus
  task automatic cycle(input bit mode, input int sel, input logic [NC-1:0] vld,
                       input logic [NC*NB-1:0] data, input bit rdy);
    bit can_load;
    bit found;
    int w;
    int c;
    logic [NC-1:0] eg;
    in_Mode  = mode;
    in_Sel   = sel[SB-1:0];
    in_Valid = vld;
    in_Data  = data;
    in_Ready = rdy;
    can_load = !m_valid || rdy;
    found = 1'b0;
    w = 0;
    if (!mode) begin
      if (sel < NC) begin
        found = vld[sel];
        w = sel;
      end
    end else begin
      for (int k = 1; k <= NC; k++) begin
        c = (m_last + k) % NC;
        if (!found && vld[c]) begin
          found = 1'b1;
          w = c;
        end
      end
    end
    eg = '0;
    if (can_load && found) eg[w] = 1'b1;
    #1;
    check("grant", 32'(out_Grant), 32'(eg));
    @(posedge clk);
    if (can_load && found) begin
      exp_q.push_back({SB'(w), data[w*NB +: NB]});
      m_valid = 1'b1;
      if (mode) m_last = w;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    m_err = !mode && (sel >= NC) && can_load;
    #1;
  endtask

  // async reset pulse between edges, checked immediately
  task automatic reset_mid();
    #2;
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(out_Valid), 32'd0);
    check("rst_data", 32'(out_Data), 32'd0);
    check("rst_sel", 32'(out_Sel), 32'd0);
    check("rst_grant", 32'(out_Grant), 32'd0);
    exp_q.delete();
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_last  = NC - 1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // monitor: the word held mid-cycle is consumed at the next edge if ready
  logic [SB+NB-1:0] mon_exp;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("valid", 32'(out_Valid), 32'(m_valid));
      check("selerr", 32'(out_SelError), 32'(m_err));
      if (out_Valid && in_Ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL word: got %0h with no expected word queued at %0t", {out_Sel, out_Data}, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", 32'({out_Sel, out_Data}), 32'(mon_exp));
        end
      end
    end
  end

  localparam logic [NC*NB-1:0] D = {8'h33, 8'h22, 8'h11};

  initial begin
    reset    = 1'b1;
    in_Mode  = 1'b0;
    in_Sel   = '0;
    in_Data  = '0;
    in_Valid = '1;
    in_Ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("init_valid", 32'(out_Valid), 32'd0);
    check("init_data", 32'(out_Data), 32'd0);
    check("init_sel", 32'(out_Sel), 32'd0);
    check("init_err", 32'(out_SelError), 32'd0);
    check("init_grant", 32'(out_Grant), 32'd0);
    reset = 1'b0;

    // direct select and out-of-range selectors (single and consecutive)
    cycle(1'b0, 1, 3'b111, D, 1'b1);
    cycle(1'b0, 3, 3'b111, D, 1'b1);
    cycle(1'b0, 0, 3'b000, D, 1'b1);
    cycle(1'b0, 2, 3'b011, D, 1'b1);
    cycle(1'b0, 3, 3'b111, D, 1'b1);
    cycle(1'b0, 3, 3'b111, D, 1'b1);
    cycle(1'b0, 0, 3'b000, D, 1'b1);

    // round-robin fairness
    for (int i = 0; i < 6; i++) cycle(1'b1, 3, 3'b111, D, 1'b1);

    // back-pressure, then release with ch1 granted
    cycle(1'b0, 0, 3'b111, D, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1, 3'b111, D, 1'b0);
    cycle(1'b0, 1, 3'b111, D, 1'b1);
    cycle(1'b0, 0, 3'b000, D, 1'b1);

    // out-of-range while blocked must not flag
    cycle(1'b0, 0, 3'b001, D, 1'b0);
    cycle(1'b0, 3, 3'b111, D, 1'b0);
    cycle(1'b0, 0, 3'b000, D, 1'b1);

    // sparse round-robin with wrap, then idle drains
    cycle(1'b1, 0, 3'b001, D, 1'b1);
    cycle(1'b1, 0, 3'b001, D, 1'b1);
    cycle(1'b1, 0, 3'b000, D, 1'b1);
    cycle(1'b1, 0, 3'b000, D, 1'b1);

    // async reset mid-stream, then first grant goes to ch0
    cycle(1'b1, 0, 3'b110, D, 1'b0);
    reset_mid();
    cycle(1'b1, 0, 3'b111, D, 1'b1);
    cycle(1'b1, 0, 3'b000, D, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'(($urandom_range(0, 1))), int'($urandom_range(0, 3)),
            NC'($urandom_range(0, 7)), (NC*NB)'($urandom),
            $urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) reset_mid();
    end
    cycle(1'b0, 0, 3'b000, D, 1'b1);
    cycle(1'b0, 0, 3'b000, D, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_n_reg_arb.md
Name: mux_n_reg_arb

Overview:
- Parametrised N:1 multiplexer with a registered output stage and valid/ready handshakes.
- Successor to the fixed 3:1 combinational datapath mux. Generalised in width and channel count.
- Adds a round-robin arbitration mode, selector range checking and back-pressure.
- Used between pipeline stages wherever several producers share one consumer, e.g. writeback source or forwarding sources.

Parameters:
- NBits, 32, data width per channel.
- NChannels, 4, number of input channels, 2..16.
- SelBits, 2, selector width; must satisfy 2^SelBits >= NChannels.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_Mode  input  1  0 = direct select by in_Sel; 1 = round-robin over valid channels.
- in_Sel  input  SelBits  channel index used in mode 0.
- in_Data  input  NChannels*NBits  flattened channel data; channel i occupies bits [i*NBits +: NBits].
- in_Valid  input  NChannels  per-channel data valid.
- out_Grant  output  NChannels  combinational one-hot; bit i = channel i consumed this cycle.
- out_Data  output  NBits  registered selected data.
- out_Valid  output  1  out_Data holds an unconsumed word.
- out_Sel  output  SelBits  index of the channel that produced out_Data.
- in_Ready  input  1  consumer accepts out_Data this cycle.
- out_SelError  output  1  registered one-cycle pulse flagging an out-of-range selector in mode 0.

Behaviour:
- Reset (async, immediate): out_Data=0, out_Valid=0, out_Sel=0, out_SelError=0, rr_ptr=NChannels-1 (so channel 0 has first priority). out_Grant=0 while reset is high.
- A reset asserted mid-transfer discards any held word; no grant is issued while reset is asserted.
- can_load = !out_Valid || in_Ready. This gives full throughput: one word per cycle when the consumer is always ready.
- Mode 0:
  - If in_Sel < NChannels, in_Valid[in_Sel]=1 and can_load, then capture channel in_Sel and set out_Grant[in_Sel]=1.
  - If in_Valid[in_Sel]=0: no capture, out_Grant=0.
  - If in_Sel >= NChannels: no capture, out_Grant=0. out_SelError=1 on the next cycle, only when can_load was true. Never latch or propagate undefined data.
- Mode 1:
  - Search channels starting at (rr_ptr+1) mod NChannels, wrapping.
  - The first channel with in_Valid set wins. If can_load, capture it, grant it and set rr_ptr to the winner.
  - If no channel is valid: no grant, rr_ptr unchanged.
  - in_Sel is ignored and out_SelError is never raised.
- Capture takes effect at the clock edge: out_Data/out_Sel are updated and out_Valid=1. Latency is 1 cycle from grant to out_Valid.
- If can_load holds and there is no capture: out_Valid goes to 0 when in_Ready=1, otherwise it holds.
- While out_Valid=1 and in_Ready=0: out_Data, out_Sel and out_Valid are frozen and out_Grant=0.
- Simultaneous consume and capture (out_Valid=1, in_Ready=1, winner present): the new word replaces the old one and out_Valid stays 1.
- in_Mode is sampled every cycle. A mode switch takes effect on the same cycle. rr_ptr is preserved across mode switches and is not updated by mode 0 grants.
- out_SelError is high for exactly one cycle per offending cycle. Consecutive bad cycles give consecutive pulses.
- out_Grant is purely combinational from in_Valid, in_Sel, in_Mode, out_Valid, in_Ready, rr_ptr and reset. It has no combinational path from in_Data.

Test Plan (NBits=8, NChannels=3, SelBits=2):
- Mode 0 direct: in_Sel=1, in_Data={8'h33,8'h22,8'h11}, in_Valid=3'b111, in_Ready=1 -> out_Grant=3'b010 the same cycle; next cycle out_Data=8'h22, out_Sel=1, out_Valid=1.
- Out-of-range: mode 0, in_Sel=3, in_Valid=3'b111 -> out_Grant=0; next cycle out_SelError=1 for one cycle and out_Valid=0.
- Round-robin fairness: mode 1, in_Valid=3'b111 held, in_Ready=1 for 6 cycles -> grants in order ch0,ch1,ch2,ch0,ch1,ch2; out_Sel follows 0,1,2,0,1,2 one cycle later.
- Back-pressure: load 8'h11 from ch0, then hold in_Ready=0 for 3 cycles -> out_Data stays 8'h11, out_Valid=1, out_Grant=0. Then set in_Ready=1 -> ch1 is granted the same cycle and out_Data=8'h22 next cycle.
- Sparse round-robin: rr_ptr=0, in_Valid=3'b001 -> wraps to grant ch0. Then in_Valid=3'b000 -> no grant, and out_Valid drops after in_Ready=1.
- Async reset mid-stream: assert reset between clock edges while out_Valid=1 -> out_Valid=0 and out_Data=0 immediately. After deassert, mode 1 with in_Valid=3'b111 -> first grant is ch0.
